// File: rtl/md_unit.sv
// md_unit: MIPS HI/LO multiply/divide unit with fixed-latency MULT/DIV and MTHI/MTLO; MD_ABORT_EN adds an abort input
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
`ifdef MD_ABORT_EN
  input  logic        abort,
`endif
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [31:0] op_a, op_b;
  logic        op_s;
  logic        kill, go, issue_mul, issue_div, do_mthi, do_mtlo, done;
  logic [63:0] ext_a, ext_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, q, r, quo, rem;
`ifdef MD_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif
  assign go        = state == IDLE && start && !kill;
  assign issue_mul = go && (md_op == 3'd1 || md_op == 3'd2);
  assign issue_div = go && (md_op == 3'd3 || md_op == 3'd4);
  assign do_mthi   = go && md_op == 3'd5;
  assign do_mtlo   = go && md_op == 3'd6;
  assign done      = state != IDLE && cnt == 8'd1 && !kill;
  assign busy      = state != IDLE;
  // Next state and cycle counter: load on issue, count down while busy, drop to IDLE on last cycle or abort
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (issue_mul) begin
      state_n = MUL;
      cnt_n   = 8'(MULT_CYCLES);
    end else if (issue_div) begin
      state_n = DIV;
      cnt_n   = 8'(DIV_CYCLES);
    end else if (state != IDLE) begin
      state_n = (kill || cnt == 8'd1) ? IDLE : state;
      cnt_n   = (kill || cnt == 8'd1) ? 8'd0 : cnt - 8'd1;
    end
  end
  // Results from latched operands; signed divide goes through magnitudes so INT_MIN/-1 wraps cleanly
  always_comb begin
    ext_a = {{32{op_s & op_a[31]}}, op_a};
    ext_b = {{32{op_s & op_b[31]}}, op_b};
    prod  = ext_a * ext_b;
    neg_a = op_s & op_a[31];
    neg_b = op_s & op_b[31];
    mag_a = neg_a ? -op_a : op_a;
    mag_b = neg_b ? -op_b : op_b;
    q     = mag_a / mag_b;
    r     = mag_a % mag_b;
    quo   = (neg_a ^ neg_b) ? -q : q;
    rem   = neg_a ? -r : r;
  end
  // FSM state and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // Operand latch at issue; HI/LO written on completion (except divide by zero) or MTHI/MTLO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a <= 32'd0;
      op_b <= 32'd0;
      op_s <= 1'b0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else begin
      if (issue_mul || issue_div) begin
        op_a <= rs_val;
        op_b <= rt_val;
        op_s <= md_op == 3'd1 || md_op == 3'd3;
      end
      if (do_mthi) hi <= rs_val;
      if (do_mtlo) lo <= rs_val;
      if (done && state == MUL) {hi, lo} <= prod;
      if (done && state == DIV && op_b != 32'd0) begin
        hi <= rem;
        lo <= quo;
      end
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit against an arithmetic reference model
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  typedef struct {logic [31:0] h; logic [31:0] l; int n;} exp_t;
  logic clk = 0, reset = 0, start = 0, abort = 0, busy;
  logic [2:0] md_op = 0;
  logic [31:0] rs_val = 0, rt_val = 0, hi, lo;
  logic [31:0] m_hi = 0, m_lo = 0;
  int checks = 0, failures = 0;
  exp_t exp_q[$];
  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
`ifdef MD_ABORT_EN
    .abort(abort),
`endif
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sp, sa, sb;
    longint unsigned up;
    e.h = m_hi;
    e.l = m_lo;
    e.n = (o <= 3'd2) ? MC : DC;
    if (o == 3'd1) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      {e.h, e.l} = sp;
    end else if (o == 3'd2) begin
      up = {32'd0, a} * {32'd0, b};
      {e.h, e.l} = up;
    end else if (o == 3'd3 && b != 0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sp = sa / sb;
      e.l = sp[31:0];
      sp = sa % sb;
      e.h = sp[31:0];
    end else if (o == 3'd4 && b != 0) begin
      e.l = a / b;
      e.h = a % b;
    end
    return e;
  endfunction
  // Monitor: counts busy cycles and checks the scoreboard whenever busy falls
  initial begin
    int nb = 0;
    logic prev = 0;
    exp_t e;
    forever begin
      @(negedge clk or negedge reset);
      if (!reset) begin
        nb = 0;
        prev = 0;
      end else begin
        if (busy) nb++;
        if (prev && !busy) begin
          if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("busy_cycles", 64'(nb), 64'(e.n));
            chk("hilo", {hi, lo}, {e.h, e.l});
          end
          nb = 0;
        end
        prev = busy;
      end
    end
  end
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1;
    md_op = o;
    rs_val = a;
    rt_val = b;
    @(posedge clk);
    #1;
    start = 0;
    md_op = 0;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!busy) return;
      @(posedge clk);
      #1;
    end
    chk("idle_timeout", 64'd1, 64'd0);
  endtask
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (o >= 3'd1 && o <= 3'd4) begin
      e = model(o, a, b);
      exp_q.push_back(e);
      m_hi = e.h;
      m_lo = e.l;
      issue(o, a, b);
      chk("busy_rise", 64'(busy), 64'd1);
      wait_idle();
    end else begin
      if (o == 3'd5) m_hi = a;
      if (o == 3'd6) m_lo = a;
      issue(o, a, b);
      chk("mt_busy", 64'(busy), 64'd0);
      chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
  initial begin
    exp_t e;
    #12;
    chk("reset_state", {31'd0, busy, hi, lo}, 96'd0);
    reset = 1;
    @(posedge clk);
    #1;
    do_op(3'd5, 32'hDEAD, 0);
    do_op(3'd6, 32'hBEEF, 0);
    #2;
    reset = 0;
    #1;
    chk("async_reset", {31'd0, busy, hi, lo}, 96'd0);
    m_hi = 0;
    m_lo = 0;
    reset = 1;
    @(posedge clk);
    #1;
    do_op(3'd6, 32'h1234, 0);
    do_op(3'd1, 32'hFFFFFFFD, 7);
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    do_op(3'd2, 32'hFFFFFFFF, 2);
    chk("multu", {hi, lo}, 64'h00000001_FFFFFFFE);
    do_op(3'd3, 32'hFFFFFFF9, 2);
    chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(3'd5, 32'hA, 0);
    do_op(3'd6, 32'hB, 0);
    do_op(3'd4, 7, 0);
    chk("divu_by_zero", {hi, lo}, 64'h0000000A_0000000B);
    do_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    chk("div_overflow", {hi, lo}, 64'h00000000_80000000);
    e = model(3'd3, 32'd100, 32'd7);
    exp_q.push_back(e);
    m_hi = e.h;
    m_lo = e.l;
    issue(3'd3, 32'd100, 32'd7);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    issue(3'd5, 32'h5555, 32'd3);
    wait_idle();
    chk("ignore_start_busy", {hi, lo}, 64'h00000002_0000000E);
    do_op(3'd0, 32'h1111, 1);
    do_op(3'd7, 32'h2222, 1);
    issue(3'd3, 32'd50, 32'd3);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 0;
    #1;
    chk("reset_mid_div", {31'd0, busy, hi, lo}, 96'd0);
    exp_q.delete();
    m_hi = 0;
    m_lo = 0;
    reset = 1;
    repeat (12) @(posedge clk);
    #1;
    chk("no_write_after_reset", {31'd0, busy, hi, lo}, 96'd0);
`ifdef MD_ABORT_EN
    exp_q.push_back('{h: m_hi, l: m_lo, n: 2});
    issue(3'd1, 2, 3);
    @(posedge clk);
    #1;
    abort = 1;
    @(posedge clk);
    #1;
    abort = 0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, {m_hi, m_lo});
    abort = 1;
    issue(3'd5, 32'h7777, 0);
    abort = 0;
    chk("abort_mthi", {31'd0, busy, hi}, {31'd0, 1'b0, m_hi});
`endif
    for (int i = 0; i < 30; i++) begin
      logic [2:0] o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 20)));
      do_op(o, a, b);
    end
    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
